// File: rtl/cp0_int_ctrl_pkg.sv
// CP0 register numbers, STATUS field positions, EXE oper codes and the
// interrupt sequencer state encoding shared by the CP0 interrupt logic.
package cp0_int_ctrl_pkg;

    localparam logic [1:0] EXE_CP_NONE  = 2'd0;
    localparam logic [1:0] EXE_CP_STORE = 2'd1;
    localparam logic [1:0] EXE_CP0_ERET = 2'd2;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [4:0] CP0_EHBR   = 5'd25;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;
    localparam int CAUSE_IP_LSB  = 8;

    typedef enum logic [1:0] {
        INT_IDLE  = 2'd0,
        INT_PEND  = 2'd1,
        INT_ENTER = 2'd2
    } int_state_t;

endpackage

// File: rtl/cp0_int_ctrl_irq_sync.sv
// Two-flop synchroniser for asynchronous level interrupt lines.
// Latency: 2 clk. No backpressure.
module cp0_int_ctrl_irq_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt sequencer: STATUS/CAUSE/EPC/EHBR, interrupt entry FSM, MTC0/MFC0/ERET.
// Entry redirect one cycle after the first safe EXE slot; ERET redirects in the same cycle.
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ  = 4,
    parameter logic [31:0] EHBR_RST = 32'h0000_0020
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [1:0]         oper,
    input  logic               exe_valid,
    input  logic               exe_stall,
    input  logic [31:0]        pc_exe,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    output logic [31:0]        cp0_rdata,
    output logic               jump_en,
    output logic [31:0]        jump_addr,
    output logic [NUM_IRQ-1:0] int_ack
);

    int_state_t         state;
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] im;
    logic [NUM_IRQ-1:0] ip;
    logic [NUM_IRQ-1:0] pend_mask;
    logic               ie;
    logic               exl;
    logic [31:0]        epc;
    logic [31:0]        ehbr;
    logic               jump_en_q;
    logic [31:0]        jump_addr_q;

    cp0_int_ctrl_irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
        .clk (clk),
        .rst (rst),
        .d   (irq),
        .q   (irq_s)
    );

    logic               exe_go;
    logic               in_enter;
    logic               safe;
    logic               mtc0_we;
    logic               eret_go;
    logic               status_wr;
    logic               ie_eff;
    logic [NUM_IRQ-1:0] im_eff;
    logic               req;

    assign exe_go   = exe_valid & ~exe_stall;
    assign in_enter = (state == INT_ENTER);
    assign safe     = exe_go & (oper == EXE_CP_NONE);
    // The EXE instruction during the redirect cycle is younger than EPC and gets squashed.
    assign mtc0_we  = exe_go & (oper == EXE_CP_STORE) & ~in_enter;
    assign eret_go  = exe_go & (oper == EXE_CP0_ERET) & ~in_enter;

    // A STATUS write in the same cycle must be able to abort a pending entry immediately.
    assign status_wr = mtc0_we & (cp0_addr == CP0_STATUS);
    assign ie_eff    = status_wr ? cp0_wdata[STATUS_IE] : ie;
    assign im_eff    = status_wr ? cp0_wdata[STATUS_IM_LSB +: NUM_IRQ] : im;
    assign req       = (|(irq_s & im)) & ie & ~exl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INT_IDLE;
            pend_mask   <= '0;
            ie          <= 1'b0;
            exl         <= 1'b0;
            im          <= '0;
            ip          <= '0;
            epc         <= '0;
            ehbr        <= EHBR_RST;
            jump_en_q   <= 1'b0;
            jump_addr_q <= '0;
            int_ack     <= '0;
        end else begin
            jump_en_q <= 1'b0;
            int_ack   <= '0;
            case (state)
                INT_IDLE: begin
                    if (req) begin
                        state     <= INT_PEND;
                        pend_mask <= irq_s & im;
                    end
                end
                INT_PEND: begin
                    if (!ie_eff || !(|(irq_s & im_eff))) begin
                        state <= INT_IDLE;
                    end else if (safe) begin
                        state       <= INT_ENTER;
                        epc         <= pc_exe;
                        ip          <= pend_mask;
                        exl         <= 1'b1;
                        jump_en_q   <= 1'b1;
                        jump_addr_q <= ehbr;
                        int_ack     <= pend_mask;
                    end
                end
                INT_ENTER: state <= INT_IDLE;
                default:   state <= INT_IDLE;
            endcase

            if (mtc0_we) begin
                case (cp0_addr)
                    CP0_STATUS: begin
                        ie  <= cp0_wdata[STATUS_IE];
                        exl <= cp0_wdata[STATUS_EXL];
                        im  <= cp0_wdata[STATUS_IM_LSB +: NUM_IRQ];
                    end
                    CP0_EPC:  epc  <= cp0_wdata;
                    CP0_EHBR: ehbr <= cp0_wdata;
                    default:  ;
                endcase
            end

            if (eret_go) begin
                exl <= 1'b0;
                ip  <= '0;
            end
        end
    end

    assign jump_en   = jump_en_q | (eret_go & ~rst);
    assign jump_addr = (eret_go & ~rst) ? epc : jump_addr_q;

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_STATUS: begin
                cp0_rdata[STATUS_IE]                 = ie;
                cp0_rdata[STATUS_EXL]                = exl;
                cp0_rdata[STATUS_IM_LSB +: NUM_IRQ]  = im;
            end
            CP0_CAUSE: cp0_rdata[CAUSE_IP_LSB +: NUM_IRQ] = ip;
            CP0_EPC:   cp0_rdata = epc;
            CP0_EHBR:  cp0_rdata = ehbr;
            default:   cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Bench for cp0_int_ctrl: redirect pulses are scored against a queue of expected
// {jump_addr, int_ack} pairs; register state is checked through MFC0 reads.
module tb_cp0_int_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq;
    logic [1:0]  oper;
    logic        exe_valid;
    logic        exe_stall;
    logic [31:0] pc_exe;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [3:0]  int_ack;

    cp0_int_ctrl #(.NUM_IRQ(4), .EHBR_RST(32'h0000_0020)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .oper      (oper),
        .exe_valid (exe_valid),
        .exe_stall (exe_stall),
        .pc_exe    (pc_exe),
        .cp0_addr  (cp0_addr),
        .cp0_wdata (cp0_wdata),
        .cp0_rdata (cp0_rdata),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .int_ack   (int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  ack;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   jcnt     = 0;
    int   jmark;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every redirect pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && jump_en) begin
            jcnt++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_jump", {31'b0, jump_en}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("jump_addr", jump_addr, e.addr);
                check_eq("int_ack", {28'b0, int_ack}, {28'b0, e.ack});
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mfc0(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check_eq(tag, cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        exe_valid = 1'b1;
        exe_stall = 1'b0;
        oper      = 2'd1;
        cp0_addr  = a;
        cp0_wdata = d;
        tick();
        oper      = 2'd0;
    endtask

    task automatic eret();
        exe_valid = 1'b1;
        exe_stall = 1'b0;
        oper      = 2'd2;
        tick();
        oper      = 2'd0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; irq = '0; oper = 2'd0; exe_valid = 1'b0; exe_stall = 1'b0;
        pc_exe = '0; cp0_addr = '0; cp0_wdata = '0;
        tick(3);
        check_eq("rst_jump_en", {31'b0, jump_en}, 32'd0);
        check_eq("rst_jump_addr", jump_addr, 32'd0);
        check_eq("rst_int_ack", {28'b0, int_ack}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: reset values
        mfc0("rst_status", 5'd12, 32'h0);
        mfc0("rst_cause",  5'd13, 32'h0);
        mfc0("rst_epc",    5'd14, 32'h0);
        mfc0("rst_ehbr",   5'd25, 32'h20);

        // 2: basic entry on irq[1]
        exe_valid = 1'b1; pc_exe = 32'h104;
        mtc0(5'd12, 32'h0000_0301);
        exp_q.push_back('{addr: 32'h20, ack: 4'b0010});
        irq = 4'b0010;
        wait_drain("entry1_timeout");
        tick();
        mfc0("entry1_epc",    5'd14, 32'h104);
        mfc0("entry1_cause",  5'd13, 32'h200);
        mfc0("entry1_status", 5'd12, 32'h303);

        // 3: EXL blocks nesting; ERET returns and the pending line is taken
        irq = 4'b0001;
        jmark = jcnt;
        tick(10);
        check_eq("exl_blocks", 32'(jcnt - jmark), 32'd0);
        exp_q.push_back('{addr: 32'h104, ack: 4'b0000});
        exp_q.push_back('{addr: 32'h20,  ack: 4'b0001});
        pc_exe = 32'h200;
        eret();
        pc_exe = 32'h300;
        mfc0("eret_status", 5'd12, 32'h301);
        mfc0("eret_cause",  5'd13, 32'h0);
        wait_drain("entry2_timeout");
        tick();
        mfc0("entry2_epc",   5'd14, 32'h300);
        mfc0("entry2_cause", 5'd13, 32'h100);
        irq = 4'b0000;
        tick(3);
        exp_q.push_back('{addr: 32'h300, ack: 4'b0000});
        eret();
        wait_drain("eret2_timeout");

        // 4: stalled EXE is never a safe point
        exe_stall = 1'b1; pc_exe = 32'h400; irq = 4'b0010;
        jmark = jcnt;
        tick(8);
        check_eq("stall_blocks", 32'(jcnt - jmark), 32'd0);
        exp_q.push_back('{addr: 32'h20, ack: 4'b0010});
        exe_stall = 1'b0; pc_exe = 32'h444;
        wait_drain("entry3_timeout");
        tick();
        mfc0("stall_epc", 5'd14, 32'h444);
        irq = 4'b0000;
        tick(3);
        exp_q.push_back('{addr: 32'h444, ack: 4'b0000});
        eret();
        wait_drain("eret3_timeout");

        // 5: clearing IE while pending aborts entry
        exe_valid = 1'b0; irq = 4'b0010;
        tick(4);
        jmark = jcnt;
        mtc0(5'd12, 32'h0);
        pc_exe = 32'h480;
        tick(6);
        check_eq("abort_no_jump", 32'(jcnt - jmark), 32'd0);
        mfc0("abort_epc",    5'd14, 32'h444);
        mfc0("abort_status", 5'd12, 32'h0);
        irq = 4'b0000;
        tick(3);

        // 6: masked lines never enter
        mtc0(5'd12, 32'h0000_0001);
        irq = 4'b1111;
        jmark = jcnt;
        tick(20);
        check_eq("masked_no_jump", 32'(jcnt - jmark), 32'd0);
        mfc0("masked_cause", 5'd13, 32'h0);
        irq = 4'b0000;
        tick(3);

        // Register file corner cases
        mtc0(5'd13, 32'hFFFF_FFFF);
        mfc0("cause_ro", 5'd13, 32'h0);
        mtc0(5'd3, 32'hDEAD_BEEF);
        mfc0("unmapped", 5'd3, 32'h0);
        oper = 2'd1; cp0_addr = 5'd14; cp0_wdata = 32'h55;
        #1;
        check_eq("raw_old", cp0_rdata, 32'h444);
        tick();
        oper = 2'd0;
        mfc0("raw_new", 5'd14, 32'h55);
        mtc0(5'd25, 32'h800);
        mfc0("ehbr_rw", 5'd25, 32'h800);

        // Two lines at once, relocated handler base
        mtc0(5'd12, 32'h0000_0F01);
        pc_exe = 32'h500;
        exp_q.push_back('{addr: 32'h800, ack: 4'b1100});
        irq = 4'b1100;
        wait_drain("entry4_timeout");
        tick();
        mfc0("multi_cause", 5'd13, 32'hC00);
        mfc0("multi_epc",   5'd14, 32'h500);
        irq = 4'b0000;
        tick(3);
        exp_q.push_back('{addr: 32'h500, ack: 4'b0000});
        eret();
        wait_drain("eret4_timeout");

        // Reset while pending: back to reset state, no redirect
        exe_valid = 1'b0; irq = 4'b0001;
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exe_valid = 1'b1;
        jmark = jcnt;
        tick(6);
        check_eq("rst_pend_no_jump", 32'(jcnt - jmark), 32'd0);
        mfc0("rst2_status", 5'd12, 32'h0);
        mfc0("rst2_ehbr",   5'd25, 32'h20);
        irq = 4'b0000;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
